// File: rtl/approx_mac_acc.sv
// approx_mac_acc: accumulates a stream of unsigned 16-bit products from an
// approximate 8x8 multiplier into a dot product.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   p_valid/p_ready    product beat handshake
//   p_data             unsigned 16-bit product
//   p_last             final product of the current dot product
//   acc_valid/ready    result handshake
//   acc_data           accumulated sum (ACC_W bits)
//   acc_cnt            number of products summed (saturates at LEN)
//   acc_ovf            sticky carry-out of the accumulator for this dot product
//
// Optional feature: define ACC_SAT_EN to clamp the sum at 2^ACC_W-1 on
// overflow instead of wrapping modulo 2^ACC_W.
module approx_mac_acc #(
  parameter int unsigned ACC_W = 24,  // 16..32
  parameter int unsigned LEN   = 16   // 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [15:0]      p_data,
  input  logic             p_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic [7:0]       acc_cnt,
  output logic             acc_ovf
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  localparam logic [7:0] LenCnt = 8'(LEN);

  state_e           state_q;
  logic [ACC_W-1:0] sum_q;
  logic [7:0]       cnt_q;
  logic             ovf_q;
  logic             p_ready_q;
  logic             acc_valid_q;

  logic [ACC_W:0]   add_full;
  logic             carry;
  logic [ACC_W-1:0] sum_next;
  logic [7:0]       cnt_next;
  logic             accept;
  logic             closing;

  always_comb begin
    add_full = {1'b0, sum_q} + {{(ACC_W + 1 - 16){1'b0}}, p_data};
    carry    = add_full[ACC_W];
`ifdef ACC_SAT_EN
    // Once clamped, further non-negative terms keep the sum at all-ones.
    sum_next = carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    sum_next = add_full[ACC_W-1:0];
`endif
    cnt_next = cnt_q + 8'd1;
    accept   = p_valid && (state_q == StAccum);
    // Reaching LEN closes the dot product, so the count can never pass LEN.
    closing  = accept && (p_last || (cnt_next == LenCnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAccum;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      p_ready_q   <= 1'b1;
      acc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            sum_q <= sum_next;
            cnt_q <= cnt_next;
            ovf_q <= ovf_q | carry;
          end
          if (closing) begin
            state_q     <= StHold;
            p_ready_q   <= 1'b0;
            acc_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (acc_ready) begin
            state_q     <= StAccum;
            sum_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            p_ready_q   <= 1'b1;
            acc_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StAccum;
        end
      endcase
    end
  end

  assign p_ready   = p_ready_q;
  assign acc_valid = acc_valid_q;
  assign acc_data  = sum_q;
  assign acc_cnt   = cnt_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: doc/approx_mac_acc.md
APPROX_MAC_ACC -- requirements
Module: approx_mac_acc

Interface
REQ-001 Parameter: ACC_W, default 24; accumulator and result width in bits, legal range 16..32.
REQ-002 Parameter: LEN, default 16; maximum number of products per dot product, legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: p_valid  input  1  product beat valid; driven by the approximate 8x8 multiplier stage.
REQ-006 Port: p_ready  output  1  product beat accepted when high together with p_valid.
REQ-007 Port: p_data  input  16  unsigned product (z of the upstream multiplier).
REQ-008 Port: p_last  input  1  marks the final product of the current dot product.
REQ-009 Port: acc_valid  output  1  result available.
REQ-010 Port: acc_ready  input  1  downstream accepts the result.
REQ-011 Port: acc_data  output  ACC_W  accumulated sum.
REQ-012 Port: acc_cnt  output  8  number of products summed into acc_data.
REQ-013 Port: acc_ovf  output  1  sticky flag: the sum exceeded 2^ACC_W-1 at some point in this dot product.

Function
REQ-014 The block is a two-state FSM: ACCUM and HOLD.
REQ-015 In ACCUM: p_ready=1, acc_valid=0; each handshake (p_valid&p_ready) adds zero-extended p_data to the running sum and increments the term count.
REQ-016 ACCUM->HOLD on the handshake where p_last=1 or the term count reaches LEN, whichever occurs first; that product is included.
REQ-017 Latency: acc_valid=1 in the cycle after the closing handshake, with acc_data, acc_cnt and acc_ovf reflecting all terms.
REQ-018 In HOLD: p_ready=0; acc_data, acc_cnt and acc_ovf are held stable until acc_ready=1.
REQ-019 HOLD->ACCUM on acc_ready=1. The next cycle starts from sum=0, count=0, ovf=0, and p_ready=1.
REQ-020 acc_ready in ACCUM is ignored. p_valid, p_data and p_last in HOLD are ignored and not consumed.
REQ-021 A cycle with p_valid=0 in ACCUM changes no state.
REQ-022 The adder is ACC_W+1 bits wide; the carry-out sets acc_ovf, which stays set until the result is consumed.
REQ-023 With LEN=1, every accepted product closes a dot product, regardless of p_last.
REQ-024 acc_cnt saturates at LEN and never wraps.

Reset
REQ-025 rst=1 forces ACCUM, sum=0, count=0, acc_ovf=0, acc_valid=0, acc_data=0 and acc_cnt=0 at the next edge; p_ready=1 from the first cycle after rst deasserts.
REQ-026 Reset mid-dot-product or in HOLD discards the partial or pending result; no acc_valid pulse follows.
REQ-027 rst has priority over every simultaneous handshake.

Configuration
REQ-028 Macro ACC_SAT_EN defined: on overflow the sum clamps to 2^ACC_W-1 and stays clamped for the remaining terms; acc_ovf=1.
REQ-029 ACC_SAT_EN undefined: the sum wraps modulo 2^ACC_W; acc_ovf=1 still reports the wrap. All other behaviour is identical.

Verification
REQ-030 LEN=4, products 100,200,300,400 on consecutive cycles, p_last=0 -> one cycle after the 4th beat: acc_valid=1, acc_data=1000, acc_cnt=4, acc_ovf=0.
REQ-031 Products 7,9 with p_last=1 on the 2nd beat -> acc_data=16, acc_cnt=2; p_ready=0 until acc_ready=1.
REQ-032 Held result with acc_ready=0 for 5 cycles while p_valid=1 -> acc_data stable, no product consumed; acc_ready=1 -> p_ready=1 next cycle, new sum starts at 0.
REQ-033 ACC_W=16, products 0xFFFF then 0x0002 with p_last=1 -> ACC_SAT_EN: acc_data=0xFFFF, acc_ovf=1; without the macro: acc_data=0x0001, acc_ovf=1.
REQ-034 rst=1 after 3 of 4 beats -> no acc_valid; a following 4-beat dot product of 1s gives acc_data=4, acc_cnt=4.
REQ-035 Random p_valid/acc_ready gaps with exhaustive 8x8 operands through the approximate multiplier -> every acc_data equals the model sum of the accepted products.
